// File: rtl/light_phase_timer_if.sv
// Signal bundle between a traffic-light controller and the phase timer.
// The controller (master) drives enable and the raw button; the timer (slave)
// returns the expiry pulses, the accepted-press pulse and the phase flag.
interface light_phase_timer_if;
    logic enable;
    logic button_raw;
    logic timer_30s;
    logic timer_3s;
    logic button;
    logic phase_short;

    modport master (
        output enable,
        output button_raw,
        input  timer_30s,
        input  timer_3s,
        input  button,
        input  phase_short
    );

    modport slave (
        input  enable,
        input  button_raw,
        output timer_30s,
        output timer_3s,
        output button,
        output phase_short
    );
endinterface

// File: rtl/light_phase_timer.sv
// Long/short phase timer for a pedestrian crossing.
// A prescaler turns CLK_HZ enabled clocks into a one-second tick; a second
// counter times the current phase. An accepted pedestrian press forces the
// short phase from a clean start and overrides any simultaneous expiry.
module light_phase_timer #(
    parameter int CLK_HZ     = 1000,
    parameter int LONG_SEC   = 30,
    parameter int SHORT_SEC  = 3,
    parameter int DEB_CYCLES = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    light_phase_timer_if.slave bus
);

    localparam int SEC_MAX = (LONG_SEC > SHORT_SEC) ? LONG_SEC : SHORT_SEC;
    localparam int PRESC_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam int SEC_W   = (SEC_MAX > 1) ? $clog2(SEC_MAX) : 1;
    localparam int DEB_W   = $clog2(DEB_CYCLES + 1);

    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(CLK_HZ - 1);
    localparam logic [SEC_W-1:0]   LONG_LAST  = SEC_W'(LONG_SEC - 1);
    localparam logic [SEC_W-1:0]   SHORT_LAST = SEC_W'(SHORT_SEC - 1);
    localparam logic [DEB_W-1:0]   DEB_LAST   = DEB_W'(DEB_CYCLES);

    typedef enum logic {
        PH_LONG  = 1'b0,
        PH_SHORT = 1'b1
    } phase_t;

    phase_t             phase_reg;
    phase_t             phase_next;
    logic [PRESC_W-1:0] presc_reg;
    logic [SEC_W-1:0]   sec_reg;

    logic               sync1_reg;
    logic               sync2_reg;
    logic               deb_reg;
    logic               deb_prev_reg;
    logic [DEB_W-1:0]   mis_cnt_reg;

    logic               tick;
    logic               long_exp;
    logic               short_exp;
    logic               press;

    logic               timer_30s_next;
    logic               timer_3s_next;
    logic               button_next;
    logic               phase_short_next;
    logic               timer_30s_reg;
    logic               timer_3s_reg;
    logic               button_reg;
    logic               phase_short_reg;

    // Two-flop synchronizer for the asynchronous button input.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_reg <= 1'b0;
            sync2_reg <= 1'b0;
        end else begin
            sync1_reg <= bus.button_raw;
            sync2_reg <= sync1_reg;
        end
    end

    // Debounce: the level flips once DEB_CYCLES disagreeing samples have been
    // recorded and the input still disagrees; any agreeing sample restarts the count.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            deb_reg     <= 1'b0;
            mis_cnt_reg <= '0;
        end else if (sync2_reg == deb_reg) begin
            mis_cnt_reg <= '0;
        end else if (mis_cnt_reg == DEB_LAST) begin
            deb_reg     <= ~deb_reg;
            mis_cnt_reg <= '0;
        end else begin
            mis_cnt_reg <= mis_cnt_reg + DEB_W'(1);
        end
    end

    // Previous debounced level, used to find the single rising edge of a press.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            deb_prev_reg <= 1'b0;
        end else begin
            deb_prev_reg <= deb_reg;
        end
    end

    assign press     = deb_reg & ~deb_prev_reg;
    assign tick      = bus.enable && (presc_reg == PRESC_LAST);
    assign long_exp  = tick && (phase_reg == PH_LONG)  && (sec_reg == LONG_LAST);
    assign short_exp = tick && (phase_reg == PH_SHORT) && (sec_reg == SHORT_LAST);

    // Prescaler: counts enabled clocks within one second; a press restarts it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            presc_reg <= '0;
        end else if (press) begin
            presc_reg <= '0;
        end else if (bus.enable) begin
            if (presc_reg == PRESC_LAST) begin
                presc_reg <= '0;
            end else begin
                presc_reg <= presc_reg + PRESC_W'(1);
            end
        end
    end

    // Second counter: counts ticks within the phase, cleared on expiry or press.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sec_reg <= '0;
        end else if (press || long_exp || short_exp) begin
            sec_reg <= '0;
        end else if (tick) begin
            sec_reg <= sec_reg + SEC_W'(1);
        end
    end

    // Phase state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            phase_reg <= PH_LONG;
        end else begin
            phase_reg <= phase_next;
        end
    end

    // Next phase: a press always lands in SHORT, otherwise expiry swaps phases.
    always_comb begin
        phase_next = phase_reg;
        if (press) begin
            phase_next = PH_SHORT;
        end else if (long_exp) begin
            phase_next = PH_SHORT;
        end else if (short_exp) begin
            phase_next = PH_LONG;
        end
    end

    // Output decode: a press masks any expiry pulse on the same edge.
    always_comb begin
        timer_30s_next   = long_exp & ~press;
        timer_3s_next    = short_exp & ~press;
        button_next      = press;
        phase_short_next = (phase_next == PH_SHORT);
    end

    // Output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            timer_30s_reg   <= 1'b0;
            timer_3s_reg    <= 1'b0;
            button_reg      <= 1'b0;
            phase_short_reg <= 1'b0;
        end else begin
            timer_30s_reg   <= timer_30s_next;
            timer_3s_reg    <= timer_3s_next;
            button_reg      <= button_next;
            phase_short_reg <= phase_short_next;
        end
    end

    assign bus.timer_30s   = timer_30s_reg;
    assign bus.timer_3s    = timer_3s_reg;
    assign bus.button      = button_reg;
    assign bus.phase_short = phase_short_reg;

endmodule

// File: tb/tb_light_phase_timer.sv
// Directed bench for light_phase_timer with a small clock (10 Hz, 3 s / 1 s
// phases, 4-cycle debounce). Edge numbers count rising edges after reset release.
module tb_light_phase_timer;

    localparam int CLK_HZ     = 10;
    localparam int LONG_SEC   = 3;
    localparam int SHORT_SEC  = 1;
    localparam int DEB_CYCLES = 4;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;

    light_phase_timer_if bus_if ();

    light_phase_timer #(
        .CLK_HZ    (CLK_HZ),
        .LONG_SEC  (LONG_SEC),
        .SHORT_SEC (SHORT_SEC),
        .DEB_CYCLES(DEB_CYCLES)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus_if)
    );

    always #5 clk = ~clk;

    typedef struct {
        int   test_id;
        int   edge_no;
        logic t30;
        logic t3;
        logic btn;
        logic ps;
    } vec_t;

    vec_t vecs[$];
    int   checks  = 0;
    int   errors  = 0;
    int   t30_cnt = 0;
    int   t3_cnt  = 0;
    int   btn_cnt = 0;

    task automatic check_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0b required=%0b", name, act, exp);
        end else begin
            $display("ok   %s = %0b", name, act);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end else begin
            $display("ok   %s = %0d", name, act);
        end
    endtask

    // One clock: outputs are sampled 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
        if (bus_if.timer_30s === 1'b1) t30_cnt++;
        if (bus_if.timer_3s === 1'b1)  t3_cnt++;
        if (bus_if.button === 1'b1)    btn_cnt++;
    endtask

    task automatic check_all_zero(input string tag);
        check_bit({tag, "_timer_30s"},   bus_if.timer_30s,   1'b0);
        check_bit({tag, "_timer_3s"},    bus_if.timer_3s,    1'b0);
        check_bit({tag, "_button"},      bus_if.button,      1'b0);
        check_bit({tag, "_phase_short"}, bus_if.phase_short, 1'b0);
    endtask

    task automatic do_reset(input bit check_outputs, input string tag);
        bus_if.enable     = 1'b0;
        bus_if.button_raw = 1'b0;
        reset_n           = 1'b0;
        step();
        if (check_outputs) check_all_zero(tag);
        step();
        reset_n = 1'b1;
        t30_cnt = 0;
        t3_cnt  = 0;
        btn_cnt = 0;
    endtask

    // Runs edges 1..last_edge from reset, applying the enable-low window and the
    // button window, and compares against every table entry of this test.
    task automatic run_seg(input int tid, input int last_edge, input int en_lo, input int en_hi,
                           input int raw_on, input int raw_off);
        int idle_pulses;
        idle_pulses = 0;
        do_reset(1'b1, $sformatf("t%0d_reset", tid));
        for (int e = 1; e <= last_edge; e++) begin
            bus_if.enable     = (e >= en_lo && e <= en_hi) ? 1'b0 : 1'b1;
            bus_if.button_raw = (e >= raw_on && e < raw_off) ? 1'b1 : 1'b0;
            step();
            if (!bus_if.enable && (bus_if.timer_30s || bus_if.timer_3s)) idle_pulses++;
            foreach (vecs[i]) begin
                if (vecs[i].test_id == tid && vecs[i].edge_no == e) begin
                    check_bit($sformatf("t%0d_e%0d_timer_30s", tid, e),   bus_if.timer_30s,   vecs[i].t30);
                    check_bit($sformatf("t%0d_e%0d_timer_3s", tid, e),    bus_if.timer_3s,    vecs[i].t3);
                    check_bit($sformatf("t%0d_e%0d_button", tid, e),      bus_if.button,      vecs[i].btn);
                    check_bit($sformatf("t%0d_e%0d_phase_short", tid, e), bus_if.phase_short, vecs[i].ps);
                end
            end
        end
        if (en_lo <= en_hi) check_int($sformatf("t%0d_pulses_while_disabled", tid), idle_pulses, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog_timeout actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int pulse_edge;
        int found;

        bus_if.enable     = 1'b0;
        bus_if.button_raw = 1'b0;

        // Free run: long expiry at 30 and 70, short expiry at 40.
        vecs.push_back('{1, 29, 1'b0, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{1, 30, 1'b1, 1'b0, 1'b0, 1'b1});
        vecs.push_back('{1, 31, 1'b0, 1'b0, 1'b0, 1'b1});
        vecs.push_back('{1, 39, 1'b0, 1'b0, 1'b0, 1'b1});
        vecs.push_back('{1, 40, 1'b0, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{1, 41, 1'b0, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{1, 69, 1'b0, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{1, 70, 1'b1, 1'b0, 1'b0, 1'b1});
        vecs.push_back('{1, 71, 1'b0, 1'b0, 1'b0, 1'b1});
        // Enable low on edges 15-24: everything slips by 10 edges.
        vecs.push_back('{2, 30, 1'b0, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{2, 39, 1'b0, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{2, 40, 1'b1, 1'b0, 1'b0, 1'b1});
        vecs.push_back('{2, 41, 1'b0, 1'b0, 1'b0, 1'b1});
        vecs.push_back('{2, 49, 1'b0, 1'b0, 1'b0, 1'b1});
        vecs.push_back('{2, 50, 1'b0, 1'b1, 1'b0, 1'b0});
        // Held press first sampled on edge 5: accepted on edge 12.
        vecs.push_back('{3, 11, 1'b0, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{3, 12, 1'b0, 1'b0, 1'b1, 1'b1});
        vecs.push_back('{3, 13, 1'b0, 1'b0, 1'b0, 1'b1});
        vecs.push_back('{3, 21, 1'b0, 1'b0, 1'b0, 1'b1});
        vecs.push_back('{3, 22, 1'b0, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{3, 51, 1'b0, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{3, 52, 1'b1, 1'b0, 1'b0, 1'b1});
        // Press accepted on edge 30, the long-expiry edge: press wins.
        vecs.push_back('{4, 29, 1'b0, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{4, 30, 1'b0, 1'b0, 1'b1, 1'b1});
        vecs.push_back('{4, 31, 1'b0, 1'b0, 1'b0, 1'b1});
        vecs.push_back('{4, 39, 1'b0, 1'b0, 1'b0, 1'b1});
        vecs.push_back('{4, 40, 1'b0, 1'b1, 1'b0, 1'b0});

        run_seg(1, 72, 0, -1, 1000, 1000);
        check_int("t1_timer_30s_count", t30_cnt, 2);
        check_int("t1_timer_3s_count",  t3_cnt,  1);

        run_seg(2, 52, 15, 24, 1000, 1000);
        check_int("t2_timer_30s_count", t30_cnt, 1);
        check_int("t2_timer_3s_count",  t3_cnt,  1);

        run_seg(3, 53, 0, -1, 5, 1000);
        check_int("t3_timer_30s_count", t30_cnt, 1);
        check_int("t3_timer_3s_count",  t3_cnt,  1);
        check_int("t3_button_count",    btn_cnt, 1);

        run_seg(4, 45, 0, -1, 23, 1000);
        check_int("t4_timer_30s_count", t30_cnt, 0);
        check_int("t4_timer_3s_count",  t3_cnt,  1);
        check_int("t4_button_count",    btn_cnt, 1);

        // Bouncy press with enable low: 1,0,1,0,1,0 then held 1 from edge 7.
        do_reset(1'b0, "t5_reset");
        pulse_edge = 0;
        for (int e = 1; e <= 25; e++) begin
            bus_if.button_raw = (e == 1 || e == 3 || e == 5 || e >= 7) ? 1'b1 : 1'b0;
            step();
            if (bus_if.button === 1'b1) pulse_edge = e;
        end
        check_int("t5_bounce_button_count", btn_cnt, 1);
        check_int("t5_bounce_pulse_edge", pulse_edge, 14);
        check_bit("t5_press_forces_short_when_disabled", bus_if.phase_short, 1'b1);
        bus_if.button_raw = 1'b0;
        for (int e = 1; e <= 20; e++) step();
        check_int("t5_release_no_pulse", btn_cnt, 1);
        pulse_edge = 0;
        for (int e = 1; e <= 20; e++) begin
            bus_if.button_raw = 1'b1;
            step();
            if (bus_if.button === 1'b1) pulse_edge = e;
        end
        check_int("t5_repress_button_count", btn_cnt, 2);
        check_int("t5_repress_pulse_edge", pulse_edge, 8);

        // Reset pulsed mid short phase: outputs drop at once, timing restarts.
        do_reset(1'b0, "t6_reset");
        bus_if.enable = 1'b1;
        for (int e = 1; e <= 35; e++) step();
        check_bit("t6_phase_short_before_reset", bus_if.phase_short, 1'b1);
        reset_n = 1'b0;
        #1;
        check_all_zero("t6_async_reset");
        step();
        reset_n = 1'b1;
        t30_cnt = 0;
        found   = 0;
        for (int k = 1; k <= 60 && found == 0; k++) begin
            step();
            if (bus_if.timer_30s === 1'b1) found = k;
        end
        check_int("t6_timer_30s_after_release", found, 30);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/light_phase_timer.md
LIGHT_PHASE_TIMER -- requirements
Module: light_phase_timer

Interface
REQ-001 The block SHALL have parameter CLK_HZ, default 1000, meaning clock cycles per one-second tick.
REQ-002 The block SHALL have parameter LONG_SEC, default 30, meaning duration in seconds of a long phase.
REQ-003 The block SHALL have parameter SHORT_SEC, default 3, meaning duration in seconds of a short phase.
REQ-004 The block SHALL have parameter DEB_CYCLES, default 16, meaning consecutive stable cycles required to accept a button level change.
REQ-005 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-006 The block SHALL have port reset_n, input, 1 bit, asynchronous active-low reset.
REQ-007 The block SHALL have port enable, input, 1 bit, where high lets phase timing advance.
REQ-008 The block SHALL have port button_raw, input, 1 bit, an asynchronous, bouncy pedestrian button with active-high level.
REQ-009 The block SHALL have port timer_30s, output, 1 bit, a one-cycle pulse at long-phase expiry.
REQ-010 The block SHALL have port timer_3s, output, 1 bit, a one-cycle pulse at short-phase expiry.
REQ-011 The block SHALL have port button, output, 1 bit, a one-cycle pulse per accepted press.
REQ-012 The block SHALL have port phase_short, output, 1 bit, high while the short phase is being timed.

Function
REQ-013 The block SHALL hold a two-state phase FSM, LONG and SHORT.
REQ-014 The phase FSM SHALL go LONG->SHORT on long expiry and SHORT->LONG on short expiry.
REQ-015 The prescaler SHALL count 0..CLK_HZ-1 on enabled edges and SHALL generate an internal tick on the edge where its count is CLK_HZ-1, then wrap to 0.
REQ-016 The second counter SHALL increment on tick. Long expiry occurs on a tick with phase LONG and count LONG_SEC-1; short expiry occurs on a tick with phase SHORT and count SHORT_SEC-1.
REQ-017 On expiry, the second counter SHALL clear to 0 on the same edge as the phase change.
REQ-018 timer_30s and timer_3s SHALL be registered and SHALL be high for exactly one cycle, asserted on the expiry edge.
REQ-019 With enable held high from reset release, the first timer_30s SHALL assert on the (LONG_SEC*CLK_HZ)-th edge.
REQ-020 The next timer_3s SHALL assert SHORT_SEC*CLK_HZ edges after the first timer_30s.
REQ-021 While enable is low, the prescaler, second counter and phase SHALL hold, and no timer pulse SHALL occur.
REQ-022 button_raw SHALL pass through a two-flop synchronizer.
REQ-023 The debounced level SHALL toggle only after the synchronized value has differed from it for DEB_CYCLES consecutive cycles; any agreement SHALL clear the mismatch count.
REQ-024 The button output SHALL be registered and SHALL pulse one cycle on each debounced 0->1 transition, never on 1->0.
REQ-025 For a clean rise, button SHALL assert on edge DEB_CYCLES+3 after the first edge sampling button_raw=1.
REQ-026 On the edge button asserts, the phase SHALL become SHORT, and the prescaler and second counter SHALL clear to 0, regardless of enable or current phase.
REQ-027 A press during SHORT SHALL restart the short phase.
REQ-028 When button and an expiry coincide, the button SHALL win: the block SHALL load SHORT with cleared counters and SHALL suppress the expiry pulse.
REQ-029 A held button SHALL produce only one pulse.
REQ-030 phase_short SHALL be registered from the phase state.
REQ-031 Counter widths SHALL be sized with clog2 of their terminal values, and no counter SHALL overflow for any legal parameter of 1 or greater.

Reset
REQ-032 reset_n low SHALL immediately set phase LONG and clear the prescaler, second counter, synchronizer flops, debounced level and mismatch count.
REQ-033 While reset_n is low, timer_30s, timer_3s, button and phase_short SHALL all be 0.
REQ-034 Reset asserted mid-phase SHALL abandon the phase, and timing SHALL restart from LONG count 0 after release.
REQ-035 Reset release SHALL be synchronous to clk by the system; the block needs no internal release synchronizer.

Verification
REQ-036 Free run (CLK_HZ=10, LONG_SEC=3, SHORT_SEC=1, enable=1, no button) -> timer_30s at edge 30, timer_3s at edge 40, timer_30s at edge 70; each pulse is one cycle wide; phase_short is high between edges 30 and 40.
REQ-037 Enable low for edges 15-24 in the REQ-036 setup -> first timer_30s moves to edge 40, with no pulses while enable is low.
REQ-038 Bouncy press (DEB_CYCLES=4): button_raw toggles every cycle for 6 cycles, then holds 1 -> exactly one button pulse 7 edges after the final stable rise; releasing then re-pressing yields a second pulse.
REQ-039 Press accepted at edge 12 during LONG -> phase_short=1 at edge 12, timer_3s at edge 22, and no timer_30s before it.
REQ-040 Button pulse coinciding with a long-expiry edge -> no timer_30s pulse; phase SHORT with counters zero; timer_3s exactly SHORT_SEC*CLK_HZ edges later.
REQ-041 reset_n pulsed low at edge 35 in the REQ-036 setup -> all outputs 0 immediately; after release, timer_30s fires 30 edges later.
